// File: rtl/fpu_cmp_unit_if.sv
// Handshake and operand/result bundle for the single-precision compare/min/max/classify unit.
// The driver side uses the master modport and the compute unit uses the slave modport.
interface fpu_cmp_unit_if;
   logic        ap_start;
   logic        ap_done;
   logic        ap_idle;
   logic        ap_ready;
   logic [31:0] val_rs1;
   logic [31:0] val_rs2;
   logic [31:0] val_funct7;
   logic [31:0] val_funct3;
   logic [31:0] agg_result_rd_f;
   logic        agg_result_rd_f_ap_vld;
   logic [31:0] agg_result_rd_i;
   logic        agg_result_rd_i_ap_vld;
   logic        agg_result_f;
   logic        agg_result_f_ap_vld;

   modport master (
      output ap_start, val_rs1, val_rs2, val_funct7, val_funct3,
      input  ap_done, ap_idle, ap_ready,
      input  agg_result_rd_f, agg_result_rd_f_ap_vld,
      input  agg_result_rd_i, agg_result_rd_i_ap_vld,
      input  agg_result_f, agg_result_f_ap_vld
   );

   modport slave (
      input  ap_start, val_rs1, val_rs2, val_funct7, val_funct3,
      output ap_done, ap_idle, ap_ready,
      output agg_result_rd_f, agg_result_rd_f_ap_vld,
      output agg_result_rd_i, agg_result_rd_i_ap_vld,
      output agg_result_f, agg_result_f_ap_vld
   );
endinterface

// File: rtl/fpu_cmp_unit.sv
// Single-precision FMIN/FMAX, sign injection, FEQ/FLT/FLE and FCLASS unit.
// Runs a three-state IDLE/CALC/DONE handshake; results hold until the next completion.
module fpu_cmp_unit (
   input  logic          ap_clk,
   input  logic          ap_rst_n,
   fpu_cmp_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

   state_t      state_q, state_d;
   logic [31:0] rs1_q, rs2_q;
   logic [6:0]  f7_q;
   logic [2:0]  f3_q;
   logic [31:0] rd_f_q, rd_i_q;
   logic        nv_q, vld_f_q, vld_i_q, vld_nv_q;

   logic [31:0] res_f_s, res_i_s;
   logic        nv_s, upd_f_s, upd_i_s, vld_f_s, vld_i_s, bad_s;
   logic        a_nan_s, b_nan_s, a_snan_s, b_snan_s;
   logic        both_zero_s, lt_s, eq_s, sign_s;
   logic [9:0]  class_s;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   function automatic logic is_snan(input logic [31:0] x);
      return is_nan(x) && !x[22];
   endfunction

   function automatic logic is_zero(input logic [31:0] x);
      return x[30:0] == 31'd0;
   endfunction

   // Total-order less-than on non-NaN operands; -0 sorts below +0.
   function automatic logic lt_total(input logic [31:0] a, input logic [31:0] b);
      logic r;
      if (a[31] != b[31]) begin
         r = a[31];
      end else if (a[31]) begin
         r = a[30:0] > b[30:0];
      end else begin
         r = a[30:0] < b[30:0];
      end
      return r;
   endfunction

   // State register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = bus.ap_start ? CALC : IDLE;
         CALC:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand capture on acceptance; later input changes are ignored.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rs1_q <= 32'd0;
         rs2_q <= 32'd0;
         f7_q  <= 7'd0;
         f3_q  <= 3'd0;
      end else if ((state_q == IDLE) && bus.ap_start) begin
         rs1_q <= bus.val_rs1;
         rs2_q <= bus.val_rs2;
         f7_q  <= bus.val_funct7[6:0];
         f3_q  <= bus.val_funct3[2:0];
      end else begin
         rs1_q <= rs1_q;
         rs2_q <= rs2_q;
         f7_q  <= f7_q;
         f3_q  <= f3_q;
      end
   end

   // Operand classification shared by all operations.
   always_comb begin
      a_nan_s     = is_nan(rs1_q);
      b_nan_s     = is_nan(rs2_q);
      a_snan_s    = is_snan(rs1_q);
      b_snan_s    = is_snan(rs2_q);
      both_zero_s = is_zero(rs1_q) && is_zero(rs2_q);
      lt_s        = lt_total(rs1_q, rs2_q);
      eq_s        = (rs1_q == rs2_q) || both_zero_s;
      class_s     = {a_nan_s && rs1_q[22],
                     a_snan_s,
                     !rs1_q[31] && (rs1_q[30:23] == 8'hFF) && (rs1_q[22:0] == 23'd0),
                     !rs1_q[31] && (rs1_q[30:23] != 8'hFF) && (rs1_q[30:23] != 8'h00),
                     !rs1_q[31] && (rs1_q[30:23] == 8'h00) && (rs1_q[22:0] != 23'd0),
                     !rs1_q[31] && is_zero(rs1_q),
                      rs1_q[31] && is_zero(rs1_q),
                      rs1_q[31] && (rs1_q[30:23] == 8'h00) && (rs1_q[22:0] != 23'd0),
                      rs1_q[31] && (rs1_q[30:23] != 8'hFF) && (rs1_q[30:23] != 8'h00),
                      rs1_q[31] && (rs1_q[30:23] == 8'hFF) && (rs1_q[22:0] == 23'd0)};
   end

   // Operation decode and result computation.
   always_comb begin
      res_f_s = 32'd0;
      res_i_s = 32'd0;
      nv_s    = 1'b0;
      upd_f_s = 1'b0;
      upd_i_s = 1'b0;
      vld_f_s = 1'b0;
      vld_i_s = 1'b0;
      bad_s   = 1'b1;
      sign_s  = 1'b0;
      case (f7_q)
         7'h14: begin
            if (f3_q <= 3'd1) begin
               bad_s   = 1'b0;
               upd_f_s = 1'b1;
               vld_f_s = 1'b1;
               nv_s    = a_snan_s || b_snan_s;
               if (a_nan_s && b_nan_s) begin
                  res_f_s = CANON_NAN;
               end else if (a_nan_s) begin
                  res_f_s = rs2_q;
               end else if (b_nan_s) begin
                  res_f_s = rs1_q;
               end else if (f3_q == 3'd0) begin
                  res_f_s = lt_s ? rs1_q : rs2_q;
               end else begin
                  res_f_s = lt_s ? rs2_q : rs1_q;
               end
            end else begin
               bad_s = 1'b1;
            end
         end
         7'h10: begin
            if (f3_q <= 3'd2) begin
               bad_s   = 1'b0;
               upd_f_s = 1'b1;
               vld_f_s = 1'b1;
               case (f3_q)
                  3'd0:    sign_s = rs2_q[31];
                  3'd1:    sign_s = ~rs2_q[31];
                  default: sign_s = rs1_q[31] ^ rs2_q[31];
               endcase
               res_f_s = {sign_s, rs1_q[30:0]};
            end else begin
               bad_s = 1'b1;
            end
         end
         7'h50: begin
            if (f3_q <= 3'd2) begin
               bad_s   = 1'b0;
               upd_i_s = 1'b1;
               vld_i_s = 1'b1;
               case (f3_q)
                  3'd2: begin
                     nv_s    = a_snan_s || b_snan_s;
                     res_i_s = {31'd0, !a_nan_s && !b_nan_s && eq_s};
                  end
                  3'd1: begin
                     nv_s    = a_nan_s || b_nan_s;
                     res_i_s = {31'd0, !a_nan_s && !b_nan_s && lt_s && !both_zero_s};
                  end
                  default: begin
                     nv_s    = a_nan_s || b_nan_s;
                     res_i_s = {31'd0, !a_nan_s && !b_nan_s && ((lt_s && !both_zero_s) || eq_s)};
                  end
               endcase
            end else begin
               bad_s = 1'b1;
            end
         end
         7'h70: begin
            if (f3_q == 3'd1) begin
               bad_s   = 1'b0;
               upd_i_s = 1'b1;
               vld_i_s = 1'b1;
               res_i_s = {22'd0, class_s};
            end else begin
               bad_s = 1'b1;
            end
         end
         default: bad_s = 1'b1;
      endcase
      // Unsupported encodings clear both results and flag NV without a result valid.
      if (bad_s) begin
         res_f_s = 32'd0;
         res_i_s = 32'd0;
         nv_s    = 1'b1;
         upd_f_s = 1'b1;
         upd_i_s = 1'b1;
         vld_f_s = 1'b0;
         vld_i_s = 1'b0;
      end else begin
         sign_s = sign_s;
      end
   end

   // Result and valid registers; written on the CALC->DONE edge, held otherwise.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rd_f_q   <= 32'd0;
         rd_i_q   <= 32'd0;
         nv_q     <= 1'b0;
         vld_f_q  <= 1'b0;
         vld_i_q  <= 1'b0;
         vld_nv_q <= 1'b0;
      end else if (state_q == CALC) begin
         rd_f_q   <= upd_f_s ? res_f_s : rd_f_q;
         rd_i_q   <= upd_i_s ? res_i_s : rd_i_q;
         nv_q     <= nv_s;
         vld_f_q  <= vld_f_s;
         vld_i_q  <= vld_i_s;
         vld_nv_q <= 1'b1;
      end else begin
         vld_f_q  <= 1'b0;
         vld_i_q  <= 1'b0;
         vld_nv_q <= 1'b0;
      end
   end

   assign bus.ap_idle                = (state_q == IDLE);
   assign bus.ap_ready               = (state_q == IDLE) && bus.ap_start && ap_rst_n;
   assign bus.ap_done                = (state_q == DONE);
   assign bus.agg_result_rd_f        = rd_f_q;
   assign bus.agg_result_rd_f_ap_vld = vld_f_q;
   assign bus.agg_result_rd_i        = rd_i_q;
   assign bus.agg_result_rd_i_ap_vld = vld_i_q;
   assign bus.agg_result_f           = nv_q;
   assign bus.agg_result_f_ap_vld    = vld_nv_q;

endmodule

// File: doc/fpu_cmp_unit.md
FPU_CMP_UNIT -- requirements
Module: fpu_cmp_unit

Interface
REQ-001 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-002 ap_clk  in  1  clock; all state updates on rising edge.
REQ-003 ap_rst_n  in  1  asynchronous active-low reset.
REQ-004 ap_start  in  1  request; sampled only in IDLE.
REQ-005 ap_done  out  1  one-cycle pulse; results valid.
REQ-006 ap_idle  out  1  high in IDLE.
REQ-007 ap_ready  out  1  high in the cycle ap_start is accepted.
REQ-008 val_rs1, val_rs2  in  32 each  IEEE-754 single operands.
REQ-009 val_funct7, val_funct3  in  32 each  opcode selectors; only bits [6:0] and [2:0] are decoded.
REQ-010 agg_result_rd_f  out  32  float result, with agg_result_rd_f_ap_vld  out  1.
REQ-011 agg_result_rd_i  out  32  integer result, with agg_result_rd_i_ap_vld  out  1.
REQ-012 agg_result_f  out  1  invalid-operation (NV) flag, with agg_result_f_ap_vld  out  1.

Function
REQ-013 FSM states: IDLE, CALC, DONE.
- IDLE -> CALC when ap_start=1.
- CALC -> DONE unconditionally.
- DONE -> IDLE unconditionally.
REQ-014 On IDLE acceptance, the block SHALL:
- latch rs1, rs2, funct7 and funct3;
- assert ap_ready combinationally that cycle.
Input changes after acceptance SHALL be ignored.
REQ-015 Latency:
- ap_done SHALL be high exactly in DONE, 2 cycles after the accepting edge.
- Throughput: one operation per 3 cycles.
- ap_start held high in DONE SHALL NOT be accepted until IDLE.
REQ-016 Decode (funct7 / funct3):
- 20/0 FMIN, 20/1 FMAX;
- 16/0 FSGNJ, 16/1 FSGNJN, 16/2 FSGNJX;
- 80/2 FEQ, 80/1 FLT, 80/0 FLE;
- 112/1 FCLASS.
REQ-017 Float ops (FMIN, FMAX, FSGNJ*) SHALL write agg_result_rd_f. Compare and FCLASS ops SHALL write agg_result_rd_i.
REQ-018 The matching *_ap_vld SHALL pulse with ap_done. agg_result_f_ap_vld SHALL pulse on every ap_done.
REQ-019 FMIN/FMAX rules:
- -0 is less than +0.
- One NaN operand: return the other operand.
- Both NaN: return 0x7FC00000.
- NV=1 if either operand is a signaling NaN.
REQ-020 Sign injection: result = {sign, rs1[30:0]}, where sign = rs2[31], ~rs2[31], or rs1[31]^rs2[31] respectively. Sign injection SHALL never raise NV.
REQ-021 Compares SHALL return 1 or 0 zero-extended.
- Any NaN operand: result 0.
- FEQ: NV=1 only on a signaling NaN.
- FLT/FLE: NV=1 on any NaN.
- +0 SHALL equal -0.
REQ-022 FCLASS SHALL return a one-hot 10-bit mask, zero-extended:
- bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0;
- bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf;
- bit8 sNaN, bit9 qNaN.
FCLASS SHALL never raise NV.
REQ-023 NaN classification: exp=0xFF with mantissa≠0 is NaN; mantissa[22]=1 is quiet, otherwise signaling.
REQ-024 Unsupported funct7/funct3: the block SHALL complete normally, drive both results 0 with NV=1, and pulse agg_result_f_ap_vld only.
REQ-025 Result registers SHALL hold their values after DONE until the next DONE.

Reset
REQ-026 While ap_rst_n=0:
- state=IDLE;
- all results, flags and vld outputs are 0;
- ap_done=0, ap_ready=0, ap_idle=1.
REQ-027 A reset asserted during CALC or DONE SHALL abort the operation. No ap_done SHALL follow, and no vld SHALL follow.

Verification
REQ-028 FMIN, rs1=0x3FC00000, rs2=0xC0800000, one-cycle ap_start -> rd_f=0xC0800000, NV=0, ap_done 2 cycles after the start edge.
REQ-029 FMAX, rs1=0x00000000, rs2=0x80000000 -> rd_f=0x00000000; FMIN on the same operands -> 0x80000000.
REQ-030 Compares with NaN operands:
- FLT, rs1=0x3F800000, rs2=0x7F800001 -> rd_i=0, NV=1.
- FEQ, rs1=0x3F800000, rs2=0x7FC00000 -> rd_i=0, NV=0.
REQ-031 FCLASS:
- 0xFF800000 -> 1
- 0x80000001 -> 4
- 0x00800000 -> 64
- 0x7F800001 -> 256
- 0x7FC00000 -> 512
REQ-032 FSGNJX, rs1=0x40000000, rs2=0x80000000 -> rd_f=0xC0000000; funct7=99 -> rd_i=rd_f=0, NV=1.
REQ-033 ap_rst_n pulsed low in CALC -> no ap_done, outputs 0, ap_idle=1. ap_start held high continuously -> ap_done every 3rd cycle.
